// File: rtl/decode_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The queue takes the slave modport; the fetch/decode side takes master.
interface decode_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);
  logic                         fe_valid;
  logic                         fe_ready;
  logic [INST_W-1:0]            fe_inst;
  logic [PC_W-1:0]              fe_pc;
  logic                         flush;
  logic                         de_valid;
  logic                         de_ready;
  logic [INST_W-1:0]            de_inst;
  logic [PC_W-1:0]              de_pc;
  logic                         de_is_jb;
  logic                         de_delay_slot;
  logic                         de_adel;
  logic [$clog2(DEPTH+1)-1:0]   de_count;

  modport slave (
    input  fe_valid, fe_inst, fe_pc, flush, de_ready,
    output fe_ready, de_valid, de_inst, de_pc, de_is_jb, de_delay_slot, de_adel, de_count
  );

  modport master (
    output fe_valid, fe_inst, fe_pc, flush, de_ready,
    input  fe_ready, de_valid, de_inst, de_pc, de_is_jb, de_delay_slot, de_adel, de_count
  );
endinterface

// File: rtl/decode_inst_queue.sv
// DEPTH-entry fetch->decode instruction FIFO with pre-decode of jump/branch class,
// delay-slot and PC-misalignment flags, plus single-cycle flush.
module decode_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  decode_inst_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DEPTH-1:0]  jb_mem;
  logic [DEPTH-1:0]  ds_mem;
  logic [DEPTH-1:0]  adel_mem;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          last_jb;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_jb;
  logic [5:0]    op;
  logic [4:0]    rt;
  logic [5:0]    funct;

  assign full  = (count == FULL);
  assign empty = (count == '0);
  assign push  = q.fe_valid & ~full & ~q.flush;
  assign pop   = ~empty & q.de_ready & ~q.flush;

  assign op    = q.fe_inst[31:26];
  assign rt    = q.fe_inst[20:16];
  assign funct = q.fe_inst[5:0];

  // Jump/branch class: J, JAL, BEQ..BGTZ, REGIMM branches, JR/JALR.
  always_comb begin
    push_jb = 1'b0;
    case (op)
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: push_jb = 1'b1;
      6'b000001: push_jb = (rt == 5'b00000) || (rt == 5'b00001) ||
                           (rt == 5'b10000) || (rt == 5'b10001);
      6'b000000: push_jb = (funct == 6'b001000) || (funct == 6'b001001);
      default:   push_jb = 1'b0;
    endcase
  end

  // Payload storage is deliberately unreset; only the control state below is.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= q.fe_inst;
      pc_mem[wr_ptr]   <= q.fe_pc;
      jb_mem[wr_ptr]   <= push_jb;
      ds_mem[wr_ptr]   <= last_jb;
      adel_mem[wr_ptr] <= |q.fe_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_jb <= 1'b0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_jb <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        last_jb <= push_jb;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign q.fe_ready      = ~full;
  assign q.de_valid      = ~empty;
  assign q.de_count      = count;
  assign q.de_inst       = empty ? '0   : inst_mem[rd_ptr];
  assign q.de_pc         = empty ? '0   : pc_mem[rd_ptr];
  assign q.de_is_jb      = empty ? 1'b0 : jb_mem[rd_ptr];
  assign q.de_delay_slot = empty ? 1'b0 : ds_mem[rd_ptr];
  assign q.de_adel       = empty ? 1'b0 : adel_mem[rd_ptr];
endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed self-checking bench for decode_inst_queue (DEPTH=4).
module tb_decode_inst_queue;
  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;

  localparam logic [31:0] ADDIU1 = 32'h24010001;
  localparam logic [31:0] ADDIU2 = 32'h24420001;
  localparam logic [31:0] BEQ    = 32'h10220003;

  decode_inst_queue_if #(.DEPTH(4), .INST_W(32), .PC_W(32)) q ();

  decode_inst_queue #(.DEPTH(4), .INST_W(32), .PC_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (q.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    q.fe_valid = 1'b1;
    q.fe_inst  = inst;
    q.fe_pc    = pc;
    step();
    q.fe_valid = 1'b0;
  endtask

  task automatic do_flush();
    q.flush = 1'b1;
    step();
    q.flush = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    vectors++; if (q.fe_ready !== 1'b1) begin miscompares++; $display("FAIL reset_fe_ready got %0b want 1", q.fe_ready); end
    vectors++; if (q.de_valid !== 1'b0) begin miscompares++; $display("FAIL reset_de_valid got %0b want 0", q.de_valid); end
    vectors++; if (q.de_count !== 3'd0) begin miscompares++; $display("FAIL reset_de_count got %0d want 0", q.de_count); end
    vectors++; if (q.de_pc !== 32'h0) begin miscompares++; $display("FAIL reset_de_pc got %h want 0", q.de_pc); end
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    push_one(ADDIU1, 32'hBFC00000);
    vectors++; if (q.de_valid !== 1'b1) begin miscompares++; $display("FAIL t1_de_valid got %0b want 1", q.de_valid); end
    vectors++; if (q.de_pc !== 32'hBFC00000) begin miscompares++; $display("FAIL t1_de_pc got %h want bfc00000", q.de_pc); end
    vectors++; if (q.de_inst !== ADDIU1) begin miscompares++; $display("FAIL t1_de_inst got %h want %h", q.de_inst, ADDIU1); end
    vectors++; if (q.de_is_jb !== 1'b0) begin miscompares++; $display("FAIL t1_is_jb got %0b want 0", q.de_is_jb); end
    vectors++; if (q.de_count !== 3'd1) begin miscompares++; $display("FAIL t1_count got %0d want 1", q.de_count); end
    step();
    vectors++; if (q.de_pc !== 32'hBFC00000) begin miscompares++; $display("FAIL t1_hold_pc got %h want bfc00000", q.de_pc); end
    do_flush();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(ADDIU1, 32'h1000 + 32'(i*4));
    vectors++; if (q.de_count !== 3'd4) begin miscompares++; $display("FAIL t2_full_count got %0d want 4", q.de_count); end
    vectors++; if (q.fe_ready !== 1'b0) begin miscompares++; $display("FAIL t2_full_ready got %0b want 0", q.fe_ready); end
    q.fe_valid = 1'b1;
    q.fe_pc    = 32'h2000;
    q.de_ready = 1'b1;
    #1;
    vectors++; if (q.fe_ready !== 1'b0) begin miscompares++; $display("FAIL t2_ready_during_pop got %0b want 0", q.fe_ready); end
    step();
    q.de_ready = 1'b0;
    vectors++; if (q.de_count !== 3'd3) begin miscompares++; $display("FAIL t2_count_after_pop got %0d want 3", q.de_count); end
    vectors++; if (q.fe_ready !== 1'b1) begin miscompares++; $display("FAIL t2_ready_next got %0b want 1", q.fe_ready); end
    vectors++; if (q.de_pc !== 32'h1004) begin miscompares++; $display("FAIL t2_head_pc got %h want 1004", q.de_pc); end
    step();
    q.fe_valid = 1'b0;
    vectors++; if (q.de_count !== 3'd4) begin miscompares++; $display("FAIL t2_refill_count got %0d want 4", q.de_count); end
    do_flush();
  endtask

  task automatic test_delay_slot();
    push_one(BEQ, 32'h3000);
    push_one(ADDIU2, 32'h3004);
    vectors++; if (q.de_is_jb !== 1'b1) begin miscompares++; $display("FAIL t3_beq_jb got %0b want 1", q.de_is_jb); end
    vectors++; if (q.de_delay_slot !== 1'b0) begin miscompares++; $display("FAIL t3_beq_ds got %0b want 0", q.de_delay_slot); end
    q.de_ready = 1'b1;
    step();
    q.de_ready = 1'b0;
    vectors++; if (q.de_is_jb !== 1'b0) begin miscompares++; $display("FAIL t3_addiu_jb got %0b want 0", q.de_is_jb); end
    vectors++; if (q.de_delay_slot !== 1'b1) begin miscompares++; $display("FAIL t3_addiu_ds got %0b want 1", q.de_delay_slot); end
    do_flush();
    push_one(BEQ, 32'h3100);
    vectors++; if (q.de_delay_slot !== 1'b0) begin miscompares++; $display("FAIL t3b_beq_ds got %0b want 0", q.de_delay_slot); end
    q.de_ready = 1'b1;
    step();
    q.de_ready = 1'b0;
    vectors++; if (q.de_valid !== 1'b0) begin miscompares++; $display("FAIL t3b_drained got %0b want 0", q.de_valid); end
    vectors++; if (q.de_delay_slot !== 1'b0) begin miscompares++; $display("FAIL t3b_empty_ds got %0b want 0", q.de_delay_slot); end
    push_one(ADDIU2, 32'h3104);
    vectors++; if (q.de_is_jb !== 1'b0) begin miscompares++; $display("FAIL t3b_addiu_jb got %0b want 0", q.de_is_jb); end
    vectors++; if (q.de_delay_slot !== 1'b1) begin miscompares++; $display("FAIL t3b_addiu_ds got %0b want 1", q.de_delay_slot); end
    do_flush();
  endtask

  task automatic test_flush();
    push_one(ADDIU1, 32'h4000);
    push_one(ADDIU1, 32'h4004);
    push_one(BEQ, 32'h4008);
    q.flush    = 1'b1;
    q.fe_valid = 1'b1;
    q.fe_inst  = ADDIU1;
    q.fe_pc    = 32'h400C;
    q.de_ready = 1'b1;
    step();
    q.flush    = 1'b0;
    q.fe_valid = 1'b0;
    q.de_ready = 1'b0;
    vectors++; if (q.de_valid !== 1'b0) begin miscompares++; $display("FAIL t4_de_valid got %0b want 0", q.de_valid); end
    vectors++; if (q.de_count !== 3'd0) begin miscompares++; $display("FAIL t4_count got %0d want 0", q.de_count); end
    vectors++; if (q.fe_ready !== 1'b1) begin miscompares++; $display("FAIL t4_fe_ready got %0b want 1", q.fe_ready); end
    push_one(ADDIU2, 32'h5000);
    vectors++; if (q.de_delay_slot !== 1'b0) begin miscompares++; $display("FAIL t4_post_flush_ds got %0b want 0", q.de_delay_slot); end
    vectors++; if (q.de_pc !== 32'h5000) begin miscompares++; $display("FAIL t4_post_flush_pc got %h want 5000", q.de_pc); end
    vectors++; if (q.de_count !== 3'd1) begin miscompares++; $display("FAIL t4_post_flush_count got %0d want 1", q.de_count); end
    do_flush();
    do_flush();
    vectors++; if (q.de_count !== 3'd0) begin miscompares++; $display("FAIL t4_empty_flush got %0d want 0", q.de_count); end
  endtask

  task automatic test_adel_jb();
    push_one(ADDIU1, 32'hBFC00002);
    vectors++; if (q.de_adel !== 1'b1) begin miscompares++; $display("FAIL t5_adel_mis got %0b want 1", q.de_adel); end
    do_flush();
    push_one(ADDIU1, 32'hBFC00004);
    vectors++; if (q.de_adel !== 1'b0) begin miscompares++; $display("FAIL t5_adel_ok got %0b want 0", q.de_adel); end
    do_flush();
    push_one(32'h03E00008, 32'h6000);
    vectors++; if (q.de_is_jb !== 1'b1) begin miscompares++; $display("FAIL t5_jr_jb got %0b want 1", q.de_is_jb); end
    do_flush();
    push_one(32'h04310002, 32'h6004);
    vectors++; if (q.de_is_jb !== 1'b1) begin miscompares++; $display("FAIL t5_bgezal_jb got %0b want 1", q.de_is_jb); end
    do_flush();
    push_one(32'h0C000010, 32'h6008);
    vectors++; if (q.de_is_jb !== 1'b1) begin miscompares++; $display("FAIL t5_jal_jb got %0b want 1", q.de_is_jb); end
    do_flush();
    push_one(32'h04020000, 32'h600C);
    vectors++; if (q.de_is_jb !== 1'b0) begin miscompares++; $display("FAIL t5_regimm_other_jb got %0b want 0", q.de_is_jb); end
    do_flush();
    push_one(32'h00000021, 32'h6010);
    vectors++; if (q.de_is_jb !== 1'b0) begin miscompares++; $display("FAIL t5_addu_jb got %0b want 0", q.de_is_jb); end
    do_flush();
  endtask

  task automatic test_back_to_back();
    q.de_ready = 1'b1;
    q.fe_valid = 1'b1;
    q.fe_inst  = ADDIU1;
    q.fe_pc    = 32'h7000;
    step();
    for (int i = 1; i < 10; i++) begin
      q.fe_pc = 32'h7000 + 32'(i*4);
      step();
      vectors++; if (q.de_count !== 3'd1) begin miscompares++; $display("FAIL t6_count[%0d] got %0d want 1", i, q.de_count); end
      vectors++; if (q.de_pc !== 32'h7000 + 32'(i*4)) begin miscompares++; $display("FAIL t6_pc[%0d] got %h want %h", i, q.de_pc, 32'h7000 + 32'(i*4)); end
    end
    resetn = 1'b0;
    #1;
    vectors++; if (q.de_valid !== 1'b0) begin miscompares++; $display("FAIL t6_rst_de_valid got %0b want 0", q.de_valid); end
    vectors++; if (q.de_count !== 3'd0) begin miscompares++; $display("FAIL t6_rst_count got %0d want 0", q.de_count); end
    vectors++; if (q.fe_ready !== 1'b1) begin miscompares++; $display("FAIL t6_rst_fe_ready got %0b want 1", q.fe_ready); end
    vectors++; if (q.de_pc !== 32'h0) begin miscompares++; $display("FAIL t6_rst_de_pc got %h want 0", q.de_pc); end
    q.fe_valid = 1'b0;
    q.de_ready = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    q.fe_valid  = 1'b0;
    q.fe_inst   = '0;
    q.fe_pc     = '0;
    q.flush     = 1'b0;
    q.de_ready  = 1'b0;
    test_reset();
    test_single_push();
    test_full();
    test_delay_slot();
    test_flush();
    test_adel_jb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
